// File: rtl/systolic_pkg.sv
// Shared types and constants for the systolic array feeder: FSM states, float32
// constants and the wavefront skew helper.
package systolic_pkg;

  localparam int FP_DW = 32;
  localparam logic [FP_DW-1:0] FLOAT_ZERO = 32'h0000_0000;
  localparam logic [FP_DW-1:0] FLOAT_ONE  = 32'h3F80_0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // True when wavefront step t carries a real element for this lane (0 <= t-lane < n).
  function automatic logic skew_valid(input int t, input int lane, input int n);
    return ((t - lane) >= 0) && ((t - lane) < n);
  endfunction

endpackage

// File: rtl/feeder_lane.sv
// One edge lane of the mesh: picks element (t - lane_idx) of its buffered
// row/column during STREAM, zero otherwise, and registers it onto the bus.
module feeder_lane
  import systolic_pkg::*;
#(
  parameter int N        = 4,
  parameter int DW       = FP_DW,
  parameter int LANE_IDX = 0,
  parameter int TW       = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic [TW-1:0]   t,
  input  logic [N*DW-1:0] entries,
  output logic [DW-1:0]   data
);

  logic [DW-1:0] sel;

  always_comb begin
    sel = DW'(FLOAT_ZERO);
    if (en && skew_valid(int'(t), LANE_IDX, N)) begin
      for (int k = 0; k < N; k++) begin
        if ((int'(t) - LANE_IDX) == k) sel = entries[k*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) data <= '0;
    else       data <= sel;
  end

endmodule

// File: rtl/systolic_feeder.sv
// Operand source for an NxN float32 MAC mesh: buffers A and B, clears the PEs,
// streams skewed wavefronts on the west/north edges, drains, then pulses done.
//
// state  | meaning
// IDLE   | accept buffer writes, wait for start
// CLEAR  | one cycle of pe_reset_n low, buses zero
// STREAM | 2N-1 wavefront steps, t = 0 .. 2N-2
// DRAIN  | N cycles of zero buses so the last products accumulate
// DONE   | one-cycle done pulse, back to IDLE
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int N  = 4,
  parameter int DW = FP_DW,
  parameter int AW = 2 * $clog2(N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load_valid,
  output logic            load_ready,
  input  logic            load_sel,
  input  logic [AW-1:0]   load_addr,
  input  logic [DW-1:0]   load_data,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic            pe_reset_n,
  output logic [N*DW-1:0] west_bus,
  output logic [N*DW-1:0] north_bus
);

  localparam int TW = $clog2(2 * N - 1);
  localparam logic [TW-1:0] T_LAST = TW'(2 * N - 2);
  localparam logic [TW-1:0] D_LAST = TW'(N - 1);

  state_t        state, state_nxt;
  logic [TW-1:0] cnt, cnt_nxt;
  logic          wr_en;
  logic          stream_nxt;

  logic [DW-1:0]   a_buf [N*N];
  logic [DW-1:0]   b_buf [N*N];
  logic [N*DW-1:0] row_entries [N];
  logic [N*DW-1:0] col_entries [N];

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_CLEAR;
      end
      ST_CLEAR: begin
        state_nxt = ST_STREAM;
        cnt_nxt   = '0;
      end
      ST_STREAM: begin
        if (cnt == T_LAST) begin
          state_nxt = ST_DRAIN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + TW'(1);
        end
      end
      ST_DRAIN: begin
        if (cnt == D_LAST) begin
          state_nxt = ST_DONE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + TW'(1);
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      load_ready <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      pe_reset_n <= 1'b1;
    end else begin
      load_ready <= (state_nxt == ST_IDLE);
      busy       <= (state_nxt == ST_CLEAR) || (state_nxt == ST_STREAM) ||
                    (state_nxt == ST_DRAIN);
      done       <= (state_nxt == ST_DONE);
      pe_reset_n <= (state_nxt != ST_CLEAR);
    end
  end

  // load_ready is high exactly while the FSM sits in IDLE.
  assign wr_en = load_valid && load_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int e = 0; e < N * N; e++) begin
        a_buf[e] <= '0;
        b_buf[e] <= '0;
      end
    end else if (wr_en) begin
      if (load_sel) b_buf[load_addr] <= load_data;
      else          a_buf[load_addr] <= load_data;
    end
  end

  assign stream_nxt = (state_nxt == ST_STREAM);

  for (genvar i = 0; i < N; i++) begin : g_lane
    for (genvar k = 0; k < N; k++) begin : g_entry
      assign row_entries[i][k*DW +: DW] = a_buf[i*N + k];
      assign col_entries[i][k*DW +: DW] = b_buf[k*N + i];
    end

    feeder_lane #(
      .N(N), .DW(DW), .LANE_IDX(i), .TW(TW)
    ) u_west (
      .clk     (clk),
      .reset   (reset),
      .en      (stream_nxt),
      .t       (cnt_nxt),
      .entries (row_entries[i]),
      .data    (west_bus[i*DW +: DW])
    );

    feeder_lane #(
      .N(N), .DW(DW), .LANE_IDX(i), .TW(TW)
    ) u_north (
      .clk     (clk),
      .reset   (reset),
      .en      (stream_nxt),
      .t       (cnt_nxt),
      .entries (col_entries[i]),
      .data    (north_bus[i*DW +: DW])
    );
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder with a behavioural 4x4 float MAC mesh on the
// edge buses.
module tb_systolic_feeder;
  import systolic_pkg::*;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam logic [31:0] FLOAT_TWO = 32'h4000_0000;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            load_valid = 1'b0;
  logic            load_ready;
  logic            load_sel = 1'b0;
  logic [AW-1:0]   load_addr = '0;
  logic [DW-1:0]   load_data = '0;
  logic            start = 1'b0;
  logic            busy;
  logic            done;
  logic            pe_reset_n;
  logic [N*DW-1:0] west_bus;
  logic [N*DW-1:0] north_bus;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0]     ma [N][N];
  logic [31:0]     mb [N][N];
  logic [N*DW-1:0] wlog [0:14];
  logic [N*DW-1:0] nlog [0:14];

  real         acc   [N][N];
  logic [31:0] a_reg [N][N];
  logic [31:0] b_reg [N][N];

  systolic_feeder #(.N(N), .DW(DW), .AW(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_sel   (load_sel),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .pe_reset_n (pe_reset_n),
    .west_bus   (west_bus),
    .north_bus  (north_bus)
  );

  always #5 clk = ~clk;

  function automatic real f2r(input logic [31:0] b);
    real m;
    int  e;
    if (b[30:0] == 31'd0) return 0.0;
    e = int'(b[30:23]) - 127;
    m = 1.0 + real'(b[22:0]) / 8388608.0;
    while (e > 0) begin m = m * 2.0; e--; end
    while (e < 0) begin m = m / 2.0; e++; end
    return b[31] ? -m : m;
  endfunction

  function automatic logic [31:0] r2f(input real r);
    real  a;
    int   e;
    logic s;
    if (r == 0.0) return 32'h0;
    s = (r < 0.0);
    a = s ? -r : r;
    e = 0;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0)  begin a = a * 2.0; e--; end
    return {s, 8'(e + 127), 23'($rtoi((a - 1.0) * 8388608.0 + 0.5))};
  endfunction

  // Behavioural PE mesh: operands move east/south one PE per cycle.
  always @(posedge clk) begin
    logic [31:0] a_in, b_in;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (j == 0) a_in = west_bus[i*DW +: DW];
        else        a_in = a_reg[i][j-1];
        if (i == 0) b_in = north_bus[j*DW +: DW];
        else        b_in = b_reg[i-1][j];
        a_reg[i][j] <= a_in;
        b_reg[i][j] <= b_in;
        acc[i][j]   <= !pe_reset_n ? 0.0 : acc[i][j] + f2r(a_in) * f2r(b_in);
      end
    end
  end

  task automatic chk(input string tag, input logic [N*DW-1:0] obs, input logic [N*DW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [N*DW-1:0] exp_west(input int t);
    logic [N*DW-1:0] v = '0;
    for (int i = 0; i < N; i++)
      if (t >= 0 && t - i >= 0 && t - i < N) v[i*DW +: DW] = ma[i][t-i];
    return v;
  endfunction

  function automatic logic [N*DW-1:0] exp_north(input int t);
    logic [N*DW-1:0] v = '0;
    for (int j = 0; j < N; j++)
      if (t >= 0 && t - j >= 0 && t - j < N) v[j*DW +: DW] = mb[t-j][j];
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic sel, input int addr, input logic [31:0] d);
    load_valid = 1'b1;
    load_sel   = sel;
    load_addr  = AW'(addr);
    load_data  = d;
    step();
    load_valid = 1'b0;
    if (sel) mb[addr / N][addr % N] = d;
    else     ma[addr / N][addr % N] = d;
  endtask

  task automatic load_ident_two();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        load(1'b0, i*N + j, (i == j) ? FLOAT_ONE : 32'h0);
        load(1'b1, i*N + j, FLOAT_TWO);
      end
  endtask

  // Start edge is cycle 0; samples cycles 1..14 against the model, done expected at 13.
  task automatic run_chk(input string tag, input bit guard);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int cyc = 1; cyc <= 14; cyc++) begin
      wlog[cyc] = west_bus;
      nlog[cyc] = north_bus;
      chk({tag, "_done"},   done,       cyc == 13);
      chk({tag, "_busy"},   busy,       cyc >= 1 && cyc <= 12);
      chk({tag, "_pe_rst"}, pe_reset_n, cyc != 1);
      chk({tag, "_ready"},  load_ready, cyc >= 14);
      chk({tag, "_west"},   west_bus,   exp_west((cyc >= 2 && cyc <= 8) ? cyc - 2 : -1));
      chk({tag, "_north"},  north_bus,  exp_north((cyc >= 2 && cyc <= 8) ? cyc - 2 : -1));
      if (guard && cyc == 4) begin
        start      = 1'b1;
        load_valid = 1'b1;
        load_sel   = 1'b0;
        load_addr  = '0;
        load_data  = 32'hDEAD_BEEF;
      end else if (guard && cyc == 5) begin
        start      = 1'b0;
        load_valid = 1'b0;
      end
      if (cyc < 14) step();
    end
  endtask

  task automatic chk_mesh(input string tag);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        chk(tag, r2f(acc[i][j]), FLOAT_TWO);
  endtask

  initial begin
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ma[i][j] = '0;
        mb[i][j] = '0;
      end

    repeat (2) step();
    reset = 1'b0;
    chk("rst_ready", load_ready, 1'b1);
    chk("rst_busy",  busy,       1'b0);
    chk("rst_done",  done,       1'b0);
    chk("rst_pe",    pe_reset_n, 1'b1);
    chk("rst_west",  west_bus,   '0);
    chk("rst_north", north_bus,  '0);

    run_chk("zero", 1'b0);

    load_ident_two();
    run_chk("ident", 1'b0);
    chk("skew_t0_west",  wlog[2], {96'h0, 32'h3F80_0000});
    chk("skew_t0_north", nlog[2], {96'h0, 32'h4000_0000});
    chk("skew_t6_west",  wlog[8], {32'h3F80_0000, 96'h0});
    chk("skew_t6_north", nlog[8], {32'h4000_0000, 96'h0});
    chk("ident_mesh_a01", r2f(acc[0][1]), FLOAT_TWO);

    run_chk("guard", 1'b1);
    run_chk("after_guard", 1'b0);
    chk("after_guard_a00", wlog[2][31:0], 32'h3F80_0000);

    load_valid = 1'b1;
    load_sel   = 1'b0;
    load_addr  = '0;
    load_data  = 32'h4040_0000;
    ma[0][0]   = 32'h4040_0000;
    run_chk("simul", 1'b0);
    load_valid = 1'b0;
    chk("simul_a00", wlog[2][31:0], 32'h4040_0000);

    start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    chk("mid_t3_west", west_bus, exp_west(3));
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_busy",  busy,       1'b0);
    chk("mid_done",  done,       1'b0);
    chk("mid_pe",    pe_reset_n, 1'b1);
    chk("mid_ready", load_ready, 1'b1);
    chk("mid_west",  west_bus,   '0);
    chk("mid_north", north_bus,  '0);
    for (int c = 0; c < 4; c++) begin
      step();
      chk("mid_no_done", done, 1'b0);
    end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ma[i][j] = '0;
        mb[i][j] = '0;
      end
    run_chk("rerun", 1'b0);

    load_ident_two();
    run_chk("mesh1", 1'b0);
    chk_mesh("mesh1_acc");
    run_chk("mesh2", 1'b0);
    chk_mesh("mesh2_acc");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
